par_ser_tx: RTL
===============

# par_ser_tx

Transmit-side parallel-to-serial stage feeding the serial-to-parallel receiver over the single-bit link. Accepts bytes into a small FIFO and shifts them out MSB-first at one bit per clk_32f cycle. Sends SYNC_BCS comma bytes (0xBC) after reset so the receiver can align and go active, and fills every idle byte slot with 0xBC. Runs entirely in the clk_32f domain; byte framing comes from an internal 3-bit counter, so no clk_4f is needed.

## Interface
- SYNC_BCS, 4: number of 0xBC bytes sent after reset before any data; range 1–15.
- DEPTH, 4: FIFO depth in bytes; power of two, 2–16.
- IDLE_CHAR, 8'hBC: byte sent during sync and idle slots.

- clk_32f  input  1  bit clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- data_in  input  8  byte to enqueue; sampled when push=1.
- push  input  1  enqueue data_in on this edge unless full=1.
- full  output  1  registered; FIFO holds DEPTH bytes.
- data_out  output  1  serial bit; register output (shift register MSB).
- byte_start  output  1  high for the one cycle in which a byte's MSB is on data_out.
- data_flag  output  1  high for the whole 8-cycle slot when that slot carries FIFO data (not IDLE_CHAR).
- sync_done  output  1  high once the SYNC_BCS commas have been sent; stays high until reset.
- overflow  output  1  sticky; set when push=1 while full=1; cleared only by reset.

## Operation
- State machine has two states: SYNC and RUN. Reset puts it in SYNC.
- Reset values: bit_cnt=7, shift register=8'h00, data_out=0, byte_start=0, data_flag=0, sync_done=0, full=0, overflow=0, FIFO empty, comma counter=0.
- A load edge is any edge where bit_cnt==7. bit_cnt then wraps to 0; otherwise it increments. The first edge after reset release is therefore a load edge.
- On a load edge, the shift register gets the next byte and byte_start is set to 1. On every other edge, the shift register shifts left by one, the LSB fills with 0, and byte_start is 0.
- Byte selection in SYNC: load IDLE_CHAR, set data_flag=0, and increment the comma counter. The load that sends comma number SYNC_BCS moves the state to RUN.
- sync_done goes to 1 on the first RUN load edge.
- Byte selection in RUN: if the FIFO is non-empty, pop its head, load it, and set data_flag=1. Otherwise load IDLE_CHAR and set data_flag=0.
- FIFO emptiness used for the pop decision is the value before the current edge. A byte pushed on a load edge is not sent in that slot.
- Bytes pushed during SYNC are held and sent in order starting with the first RUN slot.
- Push with full=1 is dropped and sets overflow, even if a pop happens on the same edge.
- Push and pop on the same edge when not full: both take effect and the occupancy is unchanged.
- Byte order is FIFO order. Bit order is MSB first, so 0xBC appears on data_out as 1,0,1,1,1,1,0,0.

## Timing
- Every byte occupies exactly 8 consecutive cycles; there are no gaps between bytes.
- Byte k (0-based) after reset starts on load edge 8k+1, counting edges after reset release.
- The MSB of a loaded byte is visible on data_out immediately after its load edge.
- Push-to-first-bit latency in RUN with an empty FIFO: 1–8 cycles. A push on a load edge waits the full 8.
- full updates on the same edge as the push or pop that changes occupancy.
- Reset asserted mid-byte: all outputs go to their reset values asynchronously, queued bytes are lost, and SYNC restarts with the full SYNC_BCS commas after release.

## Test plan
- Reset, then release with no pushes. Expect 4×(1,0,1,1,1,1,0,0) on data_out and byte_start every 8 cycles. sync_done rises on edge 33, followed by continuous 0xBC with data_flag=0.
- Push 0xFF, 0x38, 0xE0, 0x98 during SYNC. Expect full=1 after the 4th push, then bytes 5–8 to be FF, 38, E0, 98 with data_flag=1. Expect 0xBC after that and full=0 after the first pop.
- Push 5 bytes during SYNC with DEPTH=4. Expect the 5th byte dropped, overflow=1 and held until reset, and only 4 data bytes sent.
- In RUN with the FIFO empty, push 0x5A on a load edge. Expect that slot to send 0xBC and the next slot to send 0x5A.
- In RUN, push on the same edge as a pop with the FIFO full. Expect the push dropped, overflow=1, and occupancy reduced to DEPTH-1.
- Assert reset at bit 3 of a data byte with 2 bytes queued. Expect data_out=0 and full=0 immediately, then 4 fresh 0xBC after release with no stale data.

Source files
------------

// File: rtl/par_ser_tx.sv
// Transmit-side parallel-to-serial stage: byte FIFO feeding an MSB-first shifter,
// preceded by SYNC_BCS comma bytes after reset and padded with IDLE_CHAR when idle.
module par_ser_tx #(
    parameter int         SYNC_BCS  = 4,
    parameter int         DEPTH     = 4,
    parameter logic [7:0] IDLE_CHAR = 8'hBC
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       push,
    output logic       full,
    output logic       data_out,
    output logic       byte_start,
    output logic       data_flag,
    output logic       sync_done,
    output logic       overflow
);

    localparam int         AW           = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C     = (AW + 1)'(DEPTH);
    localparam logic [AW:0] ONE_C       = (AW + 1)'(1);
    localparam logic [AW:0] ZERO_C      = (AW + 1)'(0);
    localparam logic [3:0] LAST_COMMA_C = 4'(SYNC_BCS - 1);

    typedef enum logic [0:0] {
        ST_SYNC = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t        state_r;
    state_t        state_s;
    logic [2:0]    bit_cnt_r;
    logic [7:0]    shift_r;
    logic          byte_start_r;
    logic          data_flag_r;
    logic          sync_done_r;
    logic          full_r;
    logic          overflow_r;
    logic [3:0]    comma_cnt_r;
    logic [7:0]    fifo_mem_r [DEPTH];
    logic [AW-1:0] rd_ptr_r;
    logic [AW-1:0] wr_ptr_r;
    logic [AW:0]   count_r;

    logic          load_s;
    logic          pop_s;
    logic          push_ok_s;
    logic          flag_s;
    logic          comma_inc_s;
    logic [7:0]    byte_s;
    logic [AW:0]   count_s;

    // FSM state register
    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            state_r <= ST_SYNC;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and byte selection; the pop decision uses pre-edge occupancy
    always_comb begin
        state_s     = state_r;
        byte_s      = IDLE_CHAR;
        flag_s      = 1'b0;
        pop_s       = 1'b0;
        comma_inc_s = 1'b0;
        load_s      = (bit_cnt_r == 3'd7);
        push_ok_s   = push & ~full_r;
        case (state_r)
            ST_SYNC: begin
                if (load_s) begin
                    comma_inc_s = 1'b1;
                    if (comma_cnt_r == LAST_COMMA_C) begin
                        state_s = ST_RUN;
                    end else begin
                        state_s = ST_SYNC;
                    end
                end else begin
                    state_s = ST_SYNC;
                end
            end
            ST_RUN: begin
                if (load_s && (count_r != ZERO_C)) begin
                    pop_s  = 1'b1;
                    byte_s = fifo_mem_r[rd_ptr_r];
                    flag_s = 1'b1;
                end else begin
                    byte_s = IDLE_CHAR;
                    flag_s = 1'b0;
                end
            end
            default: begin
                state_s = ST_SYNC;
            end
        endcase
    end

    // Occupancy after this edge's push/pop
    always_comb begin
        count_s = count_r;
        case ({push_ok_s, pop_s})
            2'b10:   count_s = count_r + ONE_C;
            2'b01:   count_s = count_r - ONE_C;
            default: count_s = count_r;
        endcase
    end

    // Bit framing, shifter and per-slot output flags
    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            bit_cnt_r    <= 3'd7;
            shift_r      <= 8'h00;
            byte_start_r <= 1'b0;
            data_flag_r  <= 1'b0;
            sync_done_r  <= 1'b0;
            comma_cnt_r  <= 4'd0;
        end else begin
            bit_cnt_r    <= bit_cnt_r + 3'd1;
            byte_start_r <= load_s;
            if (load_s) begin
                shift_r     <= byte_s;
                data_flag_r <= flag_s;
            end else begin
                shift_r     <= {shift_r[6:0], 1'b0};
            end
            if (comma_inc_s) begin
                comma_cnt_r <= comma_cnt_r + 4'd1;
            end
            if (load_s && (state_r == ST_RUN)) begin
                sync_done_r <= 1'b1;
            end
        end
    end

    // FIFO pointers, occupancy, full and sticky overflow
    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            rd_ptr_r   <= '0;
            wr_ptr_r   <= '0;
            count_r    <= ZERO_C;
            full_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            if (push && full_r) begin
                overflow_r <= 1'b1;
            end
            count_r <= count_s;
            full_r  <= (count_s == DEPTH_C);
        end
    end

    // FIFO storage; contents are don't-care while the pointers say empty
    always_ff @(posedge clk_32f) begin
        if (push_ok_s) begin
            fifo_mem_r[wr_ptr_r] <= data_in;
        end
    end

    assign data_out   = shift_r[7];
    assign byte_start = byte_start_r;
    assign data_flag  = data_flag_r;
    assign sync_done  = sync_done_r;
    assign full       = full_r;
    assign overflow   = overflow_r;

endmodule
